ahbl_dma_ctrl: RTL and testbench
================================

# ahbl_dma_ctrl

Single-channel AHB-Lite DMA controller that fills the DMAC master slot of the SoC crossbar, currently tied off. The CPU configures it through an AHB-Lite slave register port. It then moves 32-bit words between any two crossbar-mapped addresses, for example I2S sample registers to data memory. Transfers run free or are paced by a hardware request line. Completion raises a level interrupt.

## Interface
- CNT_W, 16, width of transfer word count
- HCLK  in  1  clock for both ports
- HRESET  in  1  asynchronous, active-high reset
- HSEL  in  1  slave select (register port)
- HADDR  in  32  slave address; only [4:2] decoded
- HTRANS  in  2  slave transfer type
- HWRITE  in  1  slave write
- HREADY  in  1  slave bus ready
- HWDATA  in  32  slave write data
- HREADYOUT  out  1  slave ready; constant 1
- HRDATA  out  32  slave read data
- M_HADDR  out  32  master address
- M_HTRANS  out  2  master transfer type; only IDLE or NONSEQ
- M_HSIZE  out  3  master size; constant 3'b010
- M_HWRITE  out  1  master write
- M_HWDATA  out  32  master write data
- M_HREADY  in  1  master ready from crossbar
- M_HRDATA  in  32  master read data from crossbar
- DREQ  in  1  hardware request pulse or level, sampled each cycle
- IRQ  out  1  DONE & IRQ_EN

## Operation
- Registers are 32-bit. Offsets: 0x00 SRC, 0x04 DST, 0x08 CNT[CNT_W-1:0], 0x0C CTRL, 0x10 STATUS, 0x14 REMAIN (RO).
- CTRL bits: [0] EN, [1] SRC_INC, [2] DST_INC, [3] HW_MODE, [4] IRQ_EN.
- STATUS bits: [0] BUSY (RO), [1] DONE (write 1 to clear). Unmapped offsets read 0.
- Slave writes: the address phase is registered when HSEL & HREADY & HTRANS[1]. The register is updated in the data phase from HWDATA.
- Slave reads: HRDATA is driven combinationally from the registered address in the data phase.
- Writes to SRC, DST or CNT while BUSY=1 are ignored.
- Start: a CTRL write with EN 0→1 while idle loads the working pointers and count.
  - Working registers: cur_src←SRC, cur_dst←DST, remain←CNT.
  - Clears DONE.
  - If CNT=0: DONE sets the next cycle, EN clears, and no bus transfer occurs.
- FSM states: IDLE, WAIT_REQ, RD_A, RD_D, WR_A, WR_D.
  - IDLE → WAIT_REQ on start.
  - WAIT_REQ → RD_A when HW_MODE=0 or pend=1. Entering RD_A clears pend.
  - RD_A: M_HTRANS=NONSEQ, M_HADDR=cur_src, M_HWRITE=0. Hold until M_HREADY=1, then go to RD_D.
  - RD_D: M_HTRANS=IDLE. On M_HREADY=1, capture M_HRDATA into buf, then go to WR_A.
  - WR_A: NONSEQ, M_HADDR=cur_dst, M_HWRITE=1. Hold until M_HREADY=1, then go to WR_D.
  - WR_D: M_HWDATA=buf, IDLE. On M_HREADY=1:
    - update pointers and count: cur_src+=4 if SRC_INC; cur_dst+=4 if DST_INC; remain-=1;
    - if remain was 1, or EN=0: go to IDLE;
    - else go to WAIT_REQ.
- Completion (remain reaches 0): DONE=1 and EN clears.
- Abort: a CTRL write with EN=0 while busy finishes the in-flight word. The block then returns to IDLE with DONE unchanged. remain shows the words not yet moved.
- pend: set by DREQ=1, cleared on entry to RD_A. If DREQ=1 in the same cycle as the clear, pend stays 1.
- Pointers wrap modulo 2^32. remain is never decremented below 0.
- BUSY=1 in every state except IDLE.
- M_HWDATA holds buf in all states.
- M_HADDR holds its last value when IDLE.

## Timing
- Reset values: all registers and working registers 0, state IDLE, pend 0. Outputs: M_HTRANS=IDLE, M_HADDR=0, M_HWRITE=0, M_HWDATA=0, HRDATA=0, IRQ=0, HREADYOUT=1.
- Zero-wait bus, HW_MODE=0: 4 cycles per word (RD_A, RD_D, WR_A, WR_D), plus one WAIT_REQ cycle between words.
- First RD_A occurs 2 cycles after the CTRL write data phase.
- Each wait state on M_HREADY extends the current phase by exactly 1 cycle.
- DONE and IRQ rise the cycle after the final WR_D completes.
- Reset asserted mid-transfer forces IDLE immediately. The bus returns to IDLE with no completion of the pending data phase.

## Test plan
- SRC=0x2000_0000, DST=0x2000_0100, CNT=4, SRC_INC=DST_INC=1, IRQ_EN=1 → 4 word copies, 4 reads then 4 writes, interleaved. DONE=1, IRQ=1, REMAIN=0, 19 cycles from first RD_A to DONE.
- HW_MODE=1, SRC=0x4000_0004 fixed, DST_INC=1, CNT=3, DREQ pulses 20 cycles apart → exactly one word per pulse. Idle in WAIT_REQ between pulses.
- M_HREADY held low 3 cycles in RD_D and 2 cycles in WR_A → data is correct. Address and control are stable throughout each stall.
- CNT=0 start → no NONSEQ on the master bus, DONE=1 next cycle. Writing 0x2 to STATUS clears DONE and drops IRQ.
- CNT=8, EN cleared after word 2 begins → word 2 completes, then IDLE, REMAIN=5, DONE=0. A write to CNT during BUSY does not change CNT.
- Reset pulse during WR_A → all outputs return to reset values and STATUS reads 0.

Source files
------------

// File: rtl/ahbl_dma_ctrl.sv
// Single-channel AHB-Lite DMA controller.
// The slave port holds the configuration registers. The master port moves 32-bit words
// from a source pointer to a destination pointer, one read followed by one write.
// A transfer can run free or be paced one word per DREQ.
// Master handshake: an address phase is accepted, and a data phase completes,
// on a cycle where M_HREADY=1; until then M_HADDR/M_HTRANS/M_HWRITE stay constant.
module ahbl_dma_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             HSEL,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic             HWRITE,
    input  logic             HREADY,
    input  logic [31:0]      HWDATA,
    output logic             HREADYOUT,
    output logic [31:0]      HRDATA,
    output logic [31:0]      M_HADDR,
    output logic [1:0]       M_HTRANS,
    output logic [2:0]       M_HSIZE,
    output logic             M_HWRITE,
    output logic [31:0]      M_HWDATA,
    input  logic             M_HREADY,
    input  logic [31:0]      M_HRDATA,
    input  logic             DREQ,
    output logic             IRQ
);

    localparam logic [2:0] A_SRC    = 3'd0;
    localparam logic [2:0] A_DST    = 3'd1;
    localparam logic [2:0] A_CNT    = 3'd2;
    localparam logic [2:0] A_CTRL   = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;
    localparam logic [2:0] A_REMAIN = 3'd5;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_REQ,
        S_RD_A,
        S_RD_D,
        S_WR_A,
        S_WR_D
    } state_t;

    state_t             r_state;

    // slave address-phase capture
    logic               r_ap_valid;
    logic               r_ap_write;
    logic [2:0]         r_ap_addr;

    // programmer-visible registers
    logic [31:0]        r_src;
    logic [31:0]        r_dst;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_en;
    logic               r_src_inc;
    logic               r_dst_inc;
    logic               r_hw_mode;
    logic               r_irq_en;
    logic               r_done;

    // working state of the channel
    logic [31:0]        r_cur_src;
    logic [31:0]        r_cur_dst;
    logic [CNT_W-1:0]   r_remain;
    logic [31:0]        r_buf;
    logic               r_pend;

    logic               w_wr;
    logic               w_rd;
    logic               w_busy;
    logic               w_wr_ctrl;
    logic               w_start;
    logic               w_start_go;
    logic               w_start_zero;
    logic               w_en_eff;
    logic               w_word_done;
    logic               w_last;
    logic               w_xfer_end;
    logic               w_unused;

    assign HREADYOUT = 1'b1;
    assign M_HSIZE   = 3'b010;
    assign M_HWDATA  = r_buf;
    assign IRQ       = r_done & r_irq_en;

    assign w_wr       = r_ap_valid & r_ap_write;
    assign w_rd       = r_ap_valid & ~r_ap_write;
    assign w_busy     = (r_state != S_IDLE);
    assign w_wr_ctrl  = w_wr & (r_ap_addr == A_CTRL);

    // A start is only an EN rising edge seen while the channel is idle.
    assign w_start      = w_wr_ctrl & HWDATA[0] & ~r_en & ~w_busy;
    assign w_start_zero = w_start & (r_cnt == '0);
    assign w_start_go   = w_start & (r_cnt != '0);

    // EN as it will be after this cycle, so an abort landing on the last data
    // phase of a word still stops the channel after that word.
    assign w_en_eff    = w_wr_ctrl ? HWDATA[0] : r_en;
    assign w_word_done = (r_state == S_WR_D) & M_HREADY;
    assign w_last      = w_word_done & (r_remain == CNT_W'(1));
    assign w_xfer_end  = w_word_done & (w_last | ~w_en_eff);

    assign w_unused = &{1'b0, HADDR[31:5], HADDR[1:0], HTRANS[0]};

    // Register the slave address phase; the data phase uses it one cycle later.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_ap_valid <= 1'b0;
            r_ap_write <= 1'b0;
            r_ap_addr  <= 3'd0;
        end else if (HREADY) begin
            r_ap_valid <= HSEL & HTRANS[1];
            r_ap_write <= HWRITE;
            r_ap_addr  <= HADDR[4:2];
        end
    end

    // Register file updates plus DONE/EN side effects of start and completion.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_src     <= 32'h0;
            r_dst     <= 32'h0;
            r_cnt     <= '0;
            r_en      <= 1'b0;
            r_src_inc <= 1'b0;
            r_dst_inc <= 1'b0;
            r_hw_mode <= 1'b0;
            r_irq_en  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            if (w_wr && !w_busy && r_ap_addr == A_SRC) r_src <= HWDATA;
            if (w_wr && !w_busy && r_ap_addr == A_DST) r_dst <= HWDATA;
            if (w_wr && !w_busy && r_ap_addr == A_CNT) r_cnt <= HWDATA[CNT_W-1:0];
            if (w_wr_ctrl) begin
                r_en      <= HWDATA[0] & ~w_start_zero;
                r_src_inc <= HWDATA[1];
                r_dst_inc <= HWDATA[2];
                r_hw_mode <= HWDATA[3];
                r_irq_en  <= HWDATA[4];
            end
            if (w_wr && r_ap_addr == A_STATUS && HWDATA[1]) r_done <= 1'b0;
            if (w_start_go) r_done <= 1'b0;
            if (w_start_zero || w_last) begin
                r_done <= 1'b1;
                r_en   <= 1'b0;
            end
        end
    end

    // Slave read data, decoded from the registered address during the data phase.
    always_comb begin
        HRDATA = 32'h0;
        if (w_rd) begin
            case (r_ap_addr)
                A_SRC:    HRDATA = r_src;
                A_DST:    HRDATA = r_dst;
                A_CNT:    HRDATA = 32'(r_cnt);
                A_CTRL:   HRDATA = {27'h0, r_irq_en, r_hw_mode, r_dst_inc, r_src_inc, r_en};
                A_STATUS: HRDATA = {30'h0, r_done, w_busy};
                A_REMAIN: HRDATA = 32'(r_remain);
                default:  HRDATA = 32'h0;
            endcase
        end
    end

    // Channel FSM with registered master-bus outputs and the DREQ pending flag.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state   <= S_IDLE;
            r_cur_src <= 32'h0;
            r_cur_dst <= 32'h0;
            r_remain  <= '0;
            r_buf     <= 32'h0;
            r_pend    <= 1'b0;
            M_HADDR   <= 32'h0;
            M_HTRANS  <= HT_IDLE;
            M_HWRITE  <= 1'b0;
        end else begin
            r_pend <= r_pend | DREQ;
            case (r_state)
                S_IDLE: begin
                    M_HTRANS <= HT_IDLE;
                    if (w_start) begin
                        r_cur_src <= r_src;
                        r_cur_dst <= r_dst;
                        r_remain  <= r_cnt;
                    end
                    if (w_start_go) r_state <= S_WAIT_REQ;
                end
                S_WAIT_REQ: begin
                    if (!w_en_eff) begin
                        r_state <= S_IDLE;
                    end else if (!r_hw_mode || r_pend) begin
                        r_state  <= S_RD_A;
                        M_HTRANS <= HT_NONSEQ;
                        M_HADDR  <= r_cur_src;
                        M_HWRITE <= 1'b0;
                        r_pend   <= DREQ;
                    end
                end
                S_RD_A: begin
                    if (M_HREADY) begin
                        r_state  <= S_RD_D;
                        M_HTRANS <= HT_IDLE;
                    end
                end
                S_RD_D: begin
                    if (M_HREADY) begin
                        r_buf    <= M_HRDATA;
                        r_state  <= S_WR_A;
                        M_HTRANS <= HT_NONSEQ;
                        M_HADDR  <= r_cur_dst;
                        M_HWRITE <= 1'b1;
                    end
                end
                S_WR_A: begin
                    if (M_HREADY) begin
                        r_state  <= S_WR_D;
                        M_HTRANS <= HT_IDLE;
                    end
                end
                S_WR_D: begin
                    if (M_HREADY) begin
                        if (r_src_inc) r_cur_src <= r_cur_src + 32'd4;
                        if (r_dst_inc) r_cur_dst <= r_cur_dst + 32'd4;
                        if (r_remain != '0) r_remain <= r_remain - CNT_W'(1);
                        M_HWRITE <= 1'b0;
                        r_state  <= w_xfer_end ? S_IDLE : S_WAIT_REQ;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    M_HTRANS <= HT_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahbl_dma_ctrl.sv
// Bench for ahbl_dma_ctrl: a register-port driver, a memory-like slave on the
// master port, and a scoreboard of expected master reads and writes.
module tb_ahbl_dma_ctrl;

    localparam logic [31:0] R_SRC    = 32'h00;
    localparam logic [31:0] R_DST    = 32'h04;
    localparam logic [31:0] R_CNT    = 32'h08;
    localparam logic [31:0] R_CTRL   = 32'h0C;
    localparam logic [31:0] R_STATUS = 32'h10;
    localparam logic [31:0] R_REMAIN = 32'h14;

    logic        HCLK;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic [31:0] M_HADDR;
    logic [1:0]  M_HTRANS;
    logic [2:0]  M_HSIZE;
    logic        M_HWRITE;
    logic [31:0] M_HWDATA;
    logic        M_HREADY;
    logic [31:0] M_HRDATA;
    logic        DREQ;
    logic        IRQ;

    ahbl_dma_ctrl #(.CNT_W(16)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .HREADYOUT(HREADYOUT),
        .HRDATA(HRDATA), .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS), .M_HSIZE(M_HSIZE),
        .M_HWRITE(M_HWRITE), .M_HWDATA(M_HWDATA), .M_HREADY(M_HREADY),
        .M_HRDATA(M_HRDATA), .DREQ(DREQ), .IRQ(IRQ)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_ra_q[$];
    logic [31:0] exp_wa_q[$];
    logic [31:0] exp_wd_q[$];

    int     hr_mode = 0;
    int     rdd_n = 0;
    int     wra_n = 0;
    int     rd_seen = 0;
    int     wr_seen = 0;
    longint first_rd_t = -1;
    longint irq_t = -1;
    longint last_dp_t = 0;

    logic        dp_valid;
    logic        dp_write;
    logic [31:0] dp_addr;
    logic        prev_stall;
    logic [31:0] prev_addr;
    logic        prev_write;

    // clock and reset
    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // contents of the simulated memory: a fixed scramble of the address
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'hC3E1} + 32'h1357_9BDF;
    endfunction

    assign M_HRDATA = (dp_valid && !dp_write) ? mem_data(dp_addr) : 32'hDEAD_BEEF;

    // master-port ready: always ready, random waits, or a fixed stall pattern
    always @(negedge HCLK) begin
        case (hr_mode)
            0: M_HREADY = 1'b1;
            1: M_HREADY = ($urandom_range(0, 3) != 0);
            default: begin
                if (M_HTRANS == 2'b10 && !M_HWRITE) begin
                    rdd_n = 0;
                    wra_n = 0;
                    M_HREADY = 1'b1;
                end else if (dp_valid && !dp_write && rdd_n < 3) begin
                    rdd_n++;
                    M_HREADY = 1'b0;
                end else if (M_HTRANS == 2'b10 && M_HWRITE && wra_n < 2) begin
                    wra_n++;
                    M_HREADY = 1'b0;
                end else begin
                    M_HREADY = 1'b1;
                end
            end
        endcase
    end

    // master-port monitor and scoreboard
    always @(posedge HCLK) begin
        if (HRESET) begin
            dp_valid   <= 1'b0;
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall)
                chk("addr_hold", {29'h0, M_HTRANS, M_HWRITE, M_HADDR}, {29'h0, 2'b10, prev_write, prev_addr});
            if (dp_valid && !M_HREADY)
                chk("dp_addr_hold", 64'(M_HADDR), 64'(dp_addr));
            prev_stall <= (M_HTRANS == 2'b10) && !M_HREADY;
            prev_addr  <= M_HADDR;
            prev_write <= M_HWRITE;
            if (M_HREADY) begin
                if (dp_valid && dp_write) begin
                    if (exp_wd_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL wr_data: unexpected write data 0x%0h", M_HWDATA);
                    end else begin
                        chk("wr_data", 64'(M_HWDATA), 64'(exp_wd_q.pop_front()));
                    end
                end
                if (M_HTRANS == 2'b10) begin
                    if (M_HWRITE) begin
                        wr_seen++;
                        if (exp_wa_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL wr_addr: unexpected write to 0x%0h", M_HADDR);
                        end else begin
                            chk("wr_addr", 64'(M_HADDR), 64'(exp_wa_q.pop_front()));
                        end
                    end else begin
                        rd_seen++;
                        if (first_rd_t < 0) first_rd_t = $time - 10;
                        if (exp_ra_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL rd_addr: unexpected read of 0x%0h", M_HADDR);
                        end else begin
                            chk("rd_addr", 64'(M_HADDR), 64'(exp_ra_q.pop_front()));
                        end
                    end
                    dp_valid <= 1'b1;
                    dp_write <= M_HWRITE;
                    dp_addr  <= M_HADDR;
                end else begin
                    dp_valid <= 1'b0;
                end
            end
            if (IRQ && irq_t < 0) irq_t = $time - 10;
        end
    end

    // driver tasks: called and returning 1 time unit after a rising edge
    task automatic reg_write(input logic [31:0] a, input logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
        @(posedge HCLK); #1;
        last_dp_t = $time - 1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
        @(posedge HCLK); #1;
    endtask

    task automatic reg_read(input logic [31:0] a, output logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        d = HRDATA;
        @(posedge HCLK); #1;
    endtask

    task automatic reg_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        reg_read(a, d);
        chk(name, 64'(d), 64'(exp));
    endtask

    task automatic wait_idle(input string name);
        logic [31:0] st;
        st = 32'h1;
        for (int k = 0; k < 500; k++) begin
            reg_read(R_STATUS, st);
            if (!st[0]) break;
        end
        chk(name, 64'(st[0]), 64'd0);
    endtask

    // reference model: the word sequence a transfer of n words must produce
    task automatic model_push(input logic [31:0] src, input logic [31:0] dst,
                              input logic sinc, input logic dinc, input int n);
        logic [31:0] ra;
        logic [31:0] wa;
        for (int i = 0; i < n; i++) begin
            ra = src + (sinc ? 32'(i * 4) : 32'h0);
            wa = dst + (dinc ? 32'(i * 4) : 32'h0);
            exp_ra_q.push_back(ra);
            exp_wa_q.push_back(wa);
            exp_wd_q.push_back(mem_data(ra));
        end
    endtask

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] cnt;
        logic [4:0]  ctrl;
        int          mode;
        bit          chk_time;
        logic [31:0] exp_status;
        logic        exp_irq;
        logic [31:0] exp_remain;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v);
        hr_mode = v.mode;
        reg_write(R_SRC, v.src);
        reg_write(R_DST, v.dst);
        reg_write(R_CNT, {16'h0, v.cnt});
        model_push(v.src, v.dst, v.ctrl[1], v.ctrl[2], int'(v.cnt));
        first_rd_t = -1;
        irq_t = -1;
        reg_write(R_CTRL, {27'h0, v.ctrl});
        wait_idle("vec_busy_timeout");
        repeat (2) @(posedge HCLK);
        #1;
        hr_mode = 0;
        chk("vec_rd_left", 64'(exp_ra_q.size()), 64'd0);
        chk("vec_wr_left", 64'(exp_wd_q.size()), 64'd0);
        reg_check("vec_status", R_STATUS, v.exp_status);
        reg_check("vec_remain", R_REMAIN, v.exp_remain);
        reg_check("vec_ctrl_en_clr", R_CTRL, {27'h0, v.ctrl & 5'b11110});
        chk("vec_irq", 64'(IRQ), 64'(v.exp_irq));
        if (v.chk_time) begin
            chk("first_rd_latency", 64'(first_rd_t - last_dp_t), 64'd20);
            chk("done_latency", 64'(irq_t - first_rd_t), 64'((5 * int'(v.cnt) - 1) * 10));
        end
        reg_write(R_STATUS, 32'h2);
        reg_check("vec_status_clr", R_STATUS, 32'h0);
        chk("vec_irq_clr", 64'(IRQ), 64'd0);
        exp_ra_q.delete(); exp_wa_q.delete(); exp_wd_q.delete();
    endtask

    initial begin
        int rd0;
        int wr0;
        int k;
        HRESET = 1'b1; HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0;
        HREADY = 1'b1; HWDATA = 32'h0; DREQ = 1'b0; M_HREADY = 1'b1;

        vecs[0] = '{32'h2000_0000, 32'h2000_0100, 16'd4, 5'h17, 0, 1'b1, 32'h2, 1'b1, 32'h0};
        vecs[1] = '{32'h2000_0040, 32'h2000_0200, 16'd2, 5'h17, 2, 1'b0, 32'h2, 1'b1, 32'h0};
        vecs[2] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 16'd3, 5'h07, 1, 1'b0, 32'h2, 1'b0, 32'h0};
        vecs[3] = '{32'h3000_0000, 32'h1000_0010, 16'd5, 5'h13, 1, 1'b0, 32'h2, 1'b1, 32'h0};
        for (int i = 4; i < 8; i++) begin
            vecs[i].src  = $urandom & 32'hFFFF_FFFC;
            vecs[i].dst  = $urandom & 32'hFFFF_FFFC;
            vecs[i].cnt  = 16'($urandom_range(1, 6));
            vecs[i].ctrl = 5'h01 | 5'($urandom_range(0, 3) << 1) | 5'($urandom_range(0, 1) << 4);
            vecs[i].mode = 1;
            vecs[i].chk_time   = 1'b0;
            vecs[i].exp_status = 32'h2;
            vecs[i].exp_irq    = vecs[i].ctrl[4];
            vecs[i].exp_remain = 32'h0;
        end

        // reset state
        #1;
        chk("rst_htrans", 64'(M_HTRANS), 64'd0);
        chk("rst_haddr", 64'(M_HADDR), 64'd0);
        chk("rst_hwrite", 64'(M_HWRITE), 64'd0);
        chk("rst_hwdata", 64'(M_HWDATA), 64'd0);
        chk("rst_hsize", 64'(M_HSIZE), 64'd2);
        chk("rst_hrdata", 64'(HRDATA), 64'd0);
        chk("rst_irq", 64'(IRQ), 64'd0);
        chk("rst_hreadyout", 64'(HREADYOUT), 64'd1);
        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;
        for (int a = 0; a < 8; a++) reg_check("rst_reg", 32'(a * 4), 32'h0);
        reg_write(32'h18, 32'hFFFF_FFFF);
        reg_check("unmapped_rd", 32'h18, 32'h0);

        // table-driven transfers
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // zero-length start
        rd0 = rd_seen;
        reg_write(R_CNT, 32'h0);
        reg_write(R_CTRL, 32'h11);
        chk("cnt0_irq_next", 64'(IRQ), 64'd1);
        reg_check("cnt0_status", R_STATUS, 32'h2);
        reg_check("cnt0_ctrl", R_CTRL, 32'h10);
        chk("cnt0_no_bus", 64'(rd_seen - rd0), 64'd0);
        reg_write(R_STATUS, 32'h2);
        chk("cnt0_irq_clr", 64'(IRQ), 64'd0);
        reg_check("cnt0_status_clr", R_STATUS, 32'h0);

        // DREQ-paced transfer
        rd0 = rd_seen; wr0 = wr_seen;
        reg_write(R_SRC, 32'h4000_0004);
        reg_write(R_DST, 32'h2000_0300);
        reg_write(R_CNT, 32'd3);
        model_push(32'h4000_0004, 32'h2000_0300, 1'b0, 1'b1, 3);
        reg_write(R_CTRL, 32'h1D);
        for (int p = 0; p < 3; p++) begin
            repeat (20) @(posedge HCLK);
            #1;
            chk("hw_words_rd", 64'(rd_seen - rd0), 64'(p));
            chk("hw_words_wr", 64'(wr_seen - wr0), 64'(p));
            reg_check("hw_status_wait", R_STATUS, 32'h1);
            DREQ = 1'b1;
            @(posedge HCLK); #1;
            DREQ = 1'b0;
        end
        repeat (20) @(posedge HCLK);
        #1;
        chk("hw_words_final", 64'(wr_seen - wr0), 64'd3);
        chk("hw_left", 64'(exp_wd_q.size()), 64'd0);
        reg_check("hw_status_done", R_STATUS, 32'h2);
        chk("hw_irq", 64'(IRQ), 64'd1);
        reg_write(R_STATUS, 32'h2);

        // abort mid-transfer, and a CNT write ignored while busy
        exp_ra_q.delete(); exp_wa_q.delete(); exp_wd_q.delete();
        rd0 = rd_seen; wr0 = wr_seen;
        reg_write(R_SRC, 32'h2000_1000);
        reg_write(R_DST, 32'h2000_2000);
        reg_write(R_CNT, 32'hABCD_0008);
        model_push(32'h2000_1000, 32'h2000_2000, 1'b1, 1'b1, 3);
        reg_write(R_CTRL, 32'h17);
        for (k = 0; k < 300; k++) begin
            @(posedge HCLK); #1;
            if (rd_seen - rd0 >= 1) break;
        end
        reg_write(R_CNT, 32'h0000_0055);
        for (k = 0; k < 300; k++) begin
            @(posedge HCLK); #1;
            if (rd_seen - rd0 >= 3) break;
        end
        chk("abort_reached_w2", 64'(rd_seen - rd0), 64'd3);
        reg_write(R_CTRL, 32'h16);
        wait_idle("abort_busy_timeout");
        chk("abort_words", 64'(wr_seen - wr0), 64'd3);
        chk("abort_left", 64'(exp_wd_q.size()), 64'd0);
        reg_check("abort_remain", R_REMAIN, 32'd5);
        reg_check("abort_status", R_STATUS, 32'h0);
        reg_check("abort_cnt_kept", R_CNT, 32'd8);
        chk("abort_irq", 64'(IRQ), 64'd0);

        // reset during WR_A
        exp_ra_q.delete(); exp_wa_q.delete(); exp_wd_q.delete();
        reg_write(R_CNT, 32'd4);
        model_push(32'h2000_1000, 32'h2000_2000, 1'b1, 1'b1, 4);
        reg_write(R_CTRL, 32'h17);
        for (k = 0; k < 200; k++) begin
            @(negedge HCLK);
            if (M_HTRANS == 2'b10 && M_HWRITE) break;
        end
        chk("rst_found_wr_a", 64'(M_HTRANS == 2'b10 && M_HWRITE), 64'd1);
        HRESET = 1'b1;
        #1;
        chk("mrst_htrans", 64'(M_HTRANS), 64'd0);
        chk("mrst_haddr", 64'(M_HADDR), 64'd0);
        chk("mrst_hwrite", 64'(M_HWRITE), 64'd0);
        chk("mrst_hwdata", 64'(M_HWDATA), 64'd0);
        chk("mrst_irq", 64'(IRQ), 64'd0);
        chk("mrst_hrdata", 64'(HRDATA), 64'd0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        exp_ra_q.delete(); exp_wa_q.delete(); exp_wd_q.delete();
        reg_check("mrst_status", R_STATUS, 32'h0);
        reg_check("mrst_ctrl", R_CTRL, 32'h0);
        reg_check("mrst_src", R_SRC, 32'h0);
        repeat (5) @(posedge HCLK);
        #1;
        chk("mrst_bus_idle", 64'(M_HTRANS), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
